melody_sequencer: RTL
=====================

Name: melody_sequencer

Overview:
- Controller that sequences the piezo square-wave tone generator through a programmable note table.
- Each entry holds a half-period in iCLK cycles and a duration in ticks.
- For each entry the block drives the half-period and tone-enable to the tone generator, times the duration, and inserts an articulation gap after each note.
- Supports start/stop control, loop playback, and table writes while idle.

Parameters:
- DEPTH, 8: number of note-table entries (power of 2).
- HP_W, 21: half-period width in iCLK cycles; 31_888 at 50 MHz gives 784 Hz.
- DUR_W, 4: note duration width in ticks.
- TICK_DIV, 6_250_000: iCLK cycles per tick (125 ms at 50 MHz).
- GAP_TICKS, 1: silent ticks after every non-rest note; 0 disables the gap.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  reset, asynchronous, active-low.
- iWR_EN  in  1  table write strobe.
- iWR_ADDR  in  log2(DEPTH)  entry index.
- iWR_HP  in  HP_W  half-period; 0 = rest.
- iWR_DUR  in  DUR_W  duration in ticks; 0 = end-of-song marker.
- iSTART  in  1  start playback (level, sampled each cycle).
- iSTOP  in  1  abort playback.
- iLOOP  in  1  loop enable, latched on accepted start.
- oHALF_PERIOD  out  HP_W  half-period to the tone generator.
- oTONE_EN  out  1  tone generator enable.
- oBUSY  out  1  high in every state except IDLE.
- oDONE  out  1  one-cycle pulse on natural end of song.
- oNOTE_IDX  out  log2(DEPTH)  index of the current entry.
- oWR_ERR  out  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (async, iRST_N=0):
  - State IDLE; all outputs 0; index 0; loop latch 0; tick counter 0.
  - All table entries cleared to HP=0, DUR=0, so an unwritten table is an empty song.
- Registers: all outputs are registered.
- States and transitions:
  - IDLE:
    - iWR_EN=1 writes the entry at the next edge.
    - iSTART=1 and iSTOP=0: latch iLOOP, index := 0, go to FETCH.
  - FETCH (1 cycle): oTONE_EN=0; read entry[index].
    - DUR≠0: go to PLAY; oHALF_PERIOD := HP; clear the tick counter.
    - DUR=0 (end marker):
      - loop latched and index≠0: index := 0, stay in FETCH.
      - otherwise: go to IDLE, pulse oDONE.
    - The loop rule means an empty song with loop set stops instead of spinning.
  - PLAY:
    - oTONE_EN = (HP≠0).
    - Tick counter counts 0..TICK_DIV-1 and wraps; each wrap is one tick.
    - After DUR ticks (exactly DUR*TICK_DIV cycles):
      - HP≠0 and GAP_TICKS>0: go to GAP and clear the tick counter.
      - otherwise: advance.
  - GAP: oTONE_EN=0; oHALF_PERIOD held; after GAP_TICKS ticks, advance.
- Advance:
  - index = DEPTH-1: treated as end of song (loop back to 0 or finish, same rules as the end marker).
  - otherwise: index := index+1, go to FETCH.
- Latency: iSTART sampled at edge N → FETCH in cycle N+1 → oTONE_EN high from edge N+2.
- Inter-note overhead: one FETCH cycle with oTONE_EN=0, which is accepted.
- iSTOP in any non-IDLE state:
  - Next edge: IDLE, oTONE_EN=0, oHALF_PERIOD=0, index 0.
  - No oDONE pulse.
  - iSTOP has priority over a simultaneous iSTART.
- iSTART while busy is ignored. iSTART held high re-triggers playback after a natural finish (from IDLE, next cycle).
- iWR_EN while busy: the write is dropped and oWR_ERR pulses. A write in the same cycle as an accepted start completes, and playback reads the new data.
- oNOTE_IDX tracks index in all states; it is 0 in IDLE.
- Counters do not overflow: the tick counter is sized ceil(log2(TICK_DIV)); the duration counter is DUR_W bits and is compared for equality with DUR.

Test Plan (TICK_DIV=4, GAP_TICKS=1, DEPTH=8):
1. Reset, then start with an empty table → oBUSY high 1 cycle (FETCH), oDONE pulse, oTONE_EN never asserted.
2. Write {31888,6},{0,2},{37919,6},{0,0}, start, loop=0:
   - oTONE_EN high 24 cycles with oHALF_PERIOD=31888, then 4 gap cycles.
   - Rest entry: 8 cycles low, oNOTE_IDX=1.
   - 37919 note: 24 cycles high, then 4 gap cycles.
   - oDONE pulse; return to IDLE.
3. Same table with loop=1 → after the gap following entry 2, oNOTE_IDX returns to 0 and 31888 replays. Assert iSTOP mid-note → oTONE_EN=0 next cycle, no oDONE.
4. All 8 entries nonzero, loop=0 → song ends after entry 7 with oDONE; oNOTE_IDX never wraps to 0 while busy.
5. iWR_EN while playing → oWR_ERR pulse, table unchanged (verified by replay). Assert iSTART and iSTOP together in IDLE → stays IDLE.
6. Pull iRST_N low mid-PLAY, asynchronously → outputs 0 immediately, table cleared. After release, start → empty-song behaviour as in scenario 1.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a piezo tone generator through a note table
// with per-note duration, articulation gap, loop and stop control.
module melody_sequencer #(
  parameter int DEPTH     = 8,
  parameter int HP_W      = 21,
  parameter int DUR_W     = 4,
  parameter int TICK_DIV  = 6_250_000,
  parameter int GAP_TICKS = 1
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iWR_EN,
  input  logic [$clog2(DEPTH)-1:0] iWR_ADDR,
  input  logic [HP_W-1:0]          iWR_HP,
  input  logic [DUR_W-1:0]         iWR_DUR,
  input  logic                     iSTART,
  input  logic                     iSTOP,
  input  logic                     iLOOP,
  output logic [HP_W-1:0]          oHALF_PERIOD,
  output logic                     oTONE_EN,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic [$clog2(DEPTH)-1:0] oNOTE_IDX,
  output logic                     oWR_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_T = DUR_W'(GAP_TICKS);
  localparam bit HAS_GAP = (GAP_TICKS > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [HP_W-1:0]  hp_mem_q  [DEPTH];
  logic [HP_W-1:0]  hp_mem_d  [DEPTH];
  logic [DUR_W-1:0] dur_mem_q [DEPTH];
  logic [DUR_W-1:0] dur_mem_d [DEPTH];

  logic [AW-1:0]    idx_q, idx_d;
  logic             loop_q, loop_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [DUR_W-1:0] dcnt_q, dcnt_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic             tone_q, tone_d;
  logic             done_q, done_d;
  logic             werr_q, werr_d;

  logic [HP_W-1:0]  entry_hp;
  logic [DUR_W-1:0] entry_dur;
  logic [DUR_W-1:0] dcnt_nx;
  logic start_ok, tick_wrap, play_done, gap_done;
  logic go_gap, last, wrap_ok, advance;

  // table is frozen while busy, so the live entry can be read directly
  assign entry_hp  = hp_mem_q[idx_q];
  assign entry_dur = dur_mem_q[idx_q];
  assign start_ok  = (state_q == S_IDLE) && iSTART && !iSTOP;
  assign tick_wrap = (tick_q == TICK_LAST);
  assign dcnt_nx   = dcnt_q + DUR_W'(1);
  assign play_done = (state_q == S_PLAY) && tick_wrap
                  && (dcnt_nx == entry_dur);
  assign gap_done  = (state_q == S_GAP) && tick_wrap
                  && (dcnt_nx == GAP_T);
  assign go_gap    = HAS_GAP && (hp_q != '0);
  assign last      = (idx_q == AW'(DEPTH - 1));
  assign wrap_ok   = loop_q && (idx_q != '0);
  assign advance   = (play_done && !go_gap) || gap_done;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        hp_mem_q[i]  <= '0;
        dur_mem_q[i] <= '0;
      end
      idx_q  <= '0;
      loop_q <= 1'b0;
      tick_q <= '0;
      dcnt_q <= '0;
      hp_q   <= '0;
      tone_q <= 1'b0;
      done_q <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_mem_q  <= hp_mem_d;
      dur_mem_q <= dur_mem_d;
      idx_q     <= idx_d;
      loop_q    <= loop_d;
      tick_q    <= tick_d;
      dcnt_q    <= dcnt_d;
      hp_q      <= hp_d;
      tone_q    <= tone_d;
      done_q    <= done_d;
      werr_q    <= werr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        if (entry_dur != '0) begin
          state_d = S_PLAY;
        end else if (wrap_ok) begin
          idx_d = '0;
        end else begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (play_done && go_gap) state_d = S_GAP;
      end
      S_GAP: ;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (!last) begin
        state_d = S_FETCH;
        idx_d   = idx_q + AW'(1);
      end else if (wrap_ok) begin
        state_d = S_FETCH;
        idx_d   = '0;
      end else begin
        state_d = S_IDLE;
        idx_d   = '0;
        done_d  = 1'b1;
      end
    end
    if (iSTOP && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    hp_mem_d  = hp_mem_q;
    dur_mem_d = dur_mem_q;
    loop_d    = loop_q;
    tick_d    = '0;
    dcnt_d    = '0;
    hp_d      = hp_q;
    werr_d    = 1'b0;
    if (iWR_EN) begin
      if (state_q == S_IDLE) begin
        hp_mem_d[iWR_ADDR]  = iWR_HP;
        dur_mem_d[iWR_ADDR] = iWR_DUR;
      end else begin
        werr_d = 1'b1;
      end
    end
    if (start_ok) loop_d = iLOOP;
    if ((state_d == state_q)
        && ((state_q == S_PLAY) || (state_q == S_GAP))) begin
      tick_d = tick_wrap ? '0 : tick_q + TW'(1);
      dcnt_d = tick_wrap ? dcnt_nx : dcnt_q;
    end
    if ((state_q == S_FETCH) && (state_d == S_PLAY)) begin
      hp_d = entry_hp;
    end else if (state_d == S_IDLE) begin
      hp_d = '0;
    end
    tone_d = (state_d == S_PLAY) && (hp_d != '0);
  end

  assign oHALF_PERIOD = hp_q;
  assign oTONE_EN     = tone_q;
  assign oBUSY        = (state_q != S_IDLE);
  assign oDONE        = done_q;
  assign oNOTE_IDX    = idx_q;
  assign oWR_ERR      = werr_q;

endmodule
